// File: rtl/timer_event_sched.sv
// timer_event_sched: prescaled 32-bit timebase with NUM_CH compare channels.
// Each channel raises pending, a 1-cycle evt pulse and optionally auto-reloads.
//
// Ports:
//   clock, reset         system clock, async active-high reset
//   address, cs, write   slot register access, wr_data written on cs & write
//   read                 read strobe (reads have no side effects)
//   rd_data              combinational read data for address
//   evt[NUM_CH-1:0]      1-cycle pulse per channel match
//   irq                  registered |(pending & irq_en)
//   capture_in           async capture pin (TIMER_SCHED_CAPTURE_EN only)
//
// Build option: define TIMER_SCHED_CAPTURE_EN to add capture_in and the
// CAPTURE register; otherwise CAPTURE reads 0.
module timer_event_sched #(
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        address,
   output logic [31:0]       rd_data,
   input  logic [31:0]       wr_data,
   input  logic              read,
   input  logic              write,
   input  logic              cs,
   output logic [NUM_CH-1:0] evt,
   output logic              irq
`ifdef TIMER_SCHED_CAPTURE_EN
   ,
   input  logic              capture_in
`endif
);

   localparam logic [4:0] A_CTRL     = 5'h00;
   localparam logic [4:0] A_PRESCALE = 5'h01;
   localparam logic [4:0] A_COUNT    = 5'h02;
   localparam logic [4:0] A_PENDING  = 5'h03;
   localparam logic [4:0] A_ARM      = 5'h04;
   localparam logic [4:0] A_IRQ_EN   = 5'h05;
   localparam logic [4:0] A_CAPTURE  = 5'h06;

   logic                  go;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] presc;
   logic [31:0]           count;
   logic [31:0]           count_nxt;
   logic [NUM_CH-1:0]     pending;
   logic [NUM_CH-1:0]     arm;
   logic [NUM_CH-1:0]     irq_en;
   logic [NUM_CH-1:0]     hit;
   logic [NUM_CH-1:0]     w1c;
   logic [31:0]           cmp    [NUM_CH];
   logic [31:0]           period [NUM_CH];
   logic [31:0]           capture;
   logic                  wr_en;
   logic                  clear;
   logic                  tick;
   logic                  unused_read;

   // Reads are side-effect free, so the strobe carries no information.
   assign unused_read = read;

   assign wr_en = cs & write;
   assign clear = wr_en & (address == A_CTRL) & wr_data[0];
   // A clear cycle suppresses the tick and therefore every match.
   assign tick  = go & (presc == prescale) & ~clear;
   assign w1c   = (wr_en && address == A_PENDING) ?
                  wr_data[NUM_CH-1:0] : '0;

   always_comb begin
      count_nxt = count;
      if (clear)
         count_nxt = '0;
      else if (tick)
         count_nxt = count + 32'd1;
   end

   // Compare against the incremented value so evt lines up with COUNT==CMP.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CH; i++)
         hit[i] = tick & arm[i] & ((count + 32'd1) == cmp[i]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         go       <= 1'b0;
         prescale <= '0;
         presc    <= '0;
         count    <= '0;
         pending  <= '0;
         arm      <= '0;
         irq_en   <= '0;
         evt      <= '0;
         irq      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cmp[i]    <= '0;
            period[i] <= '0;
         end
      end else begin
         count <= count_nxt;
         if (clear || tick)
            presc <= '0;
         else if (go)
            presc <= presc + 1'b1;
         if (wr_en && address == A_CTRL)
            go <= wr_data[1];
         if (wr_en && address == A_PRESCALE)
            prescale <= wr_data[PRESCALE_W-1:0];
         if (wr_en && address == A_IRQ_EN)
            irq_en <= wr_data[NUM_CH-1:0];
         // Hardware set wins over a same-cycle W1C.
         pending <= (pending & ~w1c) | hit;
         evt     <= hit;
         irq     <= |(pending & irq_en);
         // Software writes win over hardware reload/disarm.
         if (wr_en && address == A_ARM) begin
            arm <= wr_data[NUM_CH-1:0];
         end else begin
            for (int i = 0; i < NUM_CH; i++)
               if (hit[i] && period[i] == '0)
                  arm[i] <= 1'b0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && address == 5'(8 + i))
               cmp[i] <= wr_data;
            else if (hit[i] && period[i] != '0)
               cmp[i] <= cmp[i] + period[i];
            if (wr_en && address == 5'(16 + i))
               period[i] <= wr_data;
         end
      end
   end

`ifdef TIMER_SCHED_CAPTURE_EN
   logic cap_s1;
   logic cap_s2;
   logic cap_s3;

   // Two flops resynchronise the pin, the third gives the rising edge.
   // The captured value is the COUNT that becomes visible on that edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_s1  <= 1'b0;
         cap_s2  <= 1'b0;
         cap_s3  <= 1'b0;
         capture <= '0;
      end else begin
         cap_s1 <= capture_in;
         cap_s2 <= cap_s1;
         cap_s3 <= cap_s2;
         if (cap_s2 && !cap_s3)
            capture <= count_nxt;
      end
   end
`else
   assign capture = '0;
`endif

   always_comb begin
      rd_data = '0;
      case (address)
         A_CTRL:     rd_data[1] = go;
         A_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale;
         A_COUNT:    rd_data = count;
         A_PENDING:  rd_data[NUM_CH-1:0] = pending;
         A_ARM:      rd_data[NUM_CH-1:0] = arm;
         A_IRQ_EN:   rd_data[NUM_CH-1:0] = irq_en;
         A_CAPTURE:  rd_data = capture;
         default:    rd_data = '0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == 5'(8 + i))
            rd_data = cmp[i];
         if (address == 5'(16 + i))
            rd_data = period[i];
      end
   end

endmodule

// File: tb/tb_timer_event_sched.sv
// Directed self-checking bench for timer_event_sched (NUM_CH=4).
// Each scenario task drives the slot bus and checks results inline.
module tb_timer_event_sched;

   logic        clock;
   logic        reset;
   logic [4:0]  address;
   logic [31:0] rd_data;
   logic [31:0] wr_data;
   logic        read;
   logic        write;
   logic        cs;
   logic [3:0]  evt;
   logic        irq;
   logic        capture_in;

   int checks = 0;
   int errors = 0;

   timer_event_sched #(.NUM_CH(4), .PRESCALE_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .rd_data    (rd_data),
      .wr_data    (wr_data),
      .read       (read),
      .write      (write),
      .cs         (cs),
      .evt        (evt),
      .irq        (irq)
`ifdef TIMER_SCHED_CAPTURE_EN
      ,
      .capture_in (capture_in)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clock);
      address = a;
      wr_data = d;
      cs      = 1'b1;
      write   = 1'b1;
      @(negedge clock);
      cs      = 1'b0;
      write   = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      #1;
      d       = rd_data;
      read    = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      #1;
      checks++;
      if (evt !== 4'b0000 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: evt=%b irq=%b, want 0/0", evt, irq);
      end
      for (int a = 0; a < 24; a++) begin
         rd(5'(a), d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_reg[%0h]: got %h, want 0", a, d);
         end
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_unmapped;
      logic [31:0] d;
      wr(5'h0C, 32'hDEAD_BEEF);
      wr(5'h07, 32'h1234_5678);
      wr(5'h14, 32'h0000_0005);
      rd(5'h0C, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_cmp4: got %h, want 0", d);
      end
      rd(5'h07, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_07: got %h, want 0", d);
      end
      rd(5'h14, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_period4: got %h, want 0", d);
      end
   endtask

   task automatic test_prescale;
      logic [31:0] d;
      wr(5'h01, 32'd3);
      wr(5'h00, 32'd2);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL presc_start: count=%0d, want 0", d);
      end
      repeat (3) @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL presc_3clk: count=%0d, want 0", d);
      end
      @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL presc_4clk: count=%0d, want 1", d);
      end
      repeat (4) @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL presc_8clk: count=%0d, want 2", d);
      end
      wr(5'h00, 32'd3);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL clear_count: count=%0d, want 0", d);
      end
      rd(5'h00, d);
      checks++;
      if (d !== 32'd2) begin
         errors++;
         $display("FAIL ctrl_read: got %h, want 2", d);
      end
      repeat (3) @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL clear_presc: count=%0d, want 0", d);
      end
      @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL clear_restart: count=%0d, want 1", d);
      end
      wr(5'h00, 32'd1);
   endtask

   task automatic test_oneshot;
      logic [31:0] d;
      logic [31:0] c_at;
      logic        irq_at;
      logic        irq_nx;
      bit          grab;
      int          pulses;
      c_at   = '0;
      irq_at = 1'bx;
      irq_nx = 1'bx;
      grab   = 0;
      pulses = 0;
      wr(5'h01, 32'd0);
      wr(5'h08, 32'd10);
      wr(5'h10, 32'd0);
      wr(5'h04, 32'd1);
      wr(5'h05, 32'd1);
      wr(5'h00, 32'd2);
      address = 5'h02;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         #1;
         if (grab) begin
            irq_nx = irq;
            grab   = 0;
         end
         if (evt[0]) begin
            pulses++;
            c_at   = rd_data;
            irq_at = irq;
            grab   = 1;
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL oneshot_pulses: got %0d, want 1", pulses);
      end
      checks++;
      if (c_at !== 32'd10) begin
         errors++;
         $display("FAIL oneshot_align: count=%0d, want 10", c_at);
      end
      checks++;
      if (irq_at !== 1'b0 || irq_nx !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_irq: irq=%b then %b, want 0 then 1",
                  irq_at, irq_nx);
      end
      rd(5'h04, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL oneshot_disarm: arm=%h, want 0", d);
      end
      rd(5'h03, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL oneshot_pending: pending=%h, want 1", d);
      end
      wr(5'h03, 32'd1);
      @(negedge clock);
      #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq: irq=%b, want 0", irq);
      end
      rd(5'h03, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL w1c_pending: pending=%h, want 0", d);
      end
      wr(5'h00, 32'd1);
   endtask

   task automatic test_periodic;
      logic [31:0] d;
      logic [31:0] vals [8];
      int          n;
      n = 0;
      wr(5'h09, 32'd5);
      wr(5'h11, 32'd5);
      wr(5'h03, 32'hF);
      wr(5'h04, 32'd2);
      wr(5'h00, 32'd2);
      address = 5'h02;
      for (int k = 0; k < 22; k++) begin
         @(negedge clock);
         #1;
         if (evt[1] && n < 8) begin
            vals[n] = rd_data;
            n++;
         end
      end
      checks++;
      if (n != 4 || vals[0] !== 32'd5 || vals[1] !== 32'd10 ||
          vals[2] !== 32'd15 || vals[3] !== 32'd20) begin
         errors++;
         $display("FAIL periodic_seq: n=%0d %0d %0d %0d %0d, want 4: 5 10 15 20",
                  n, vals[0], vals[1], vals[2], vals[3]);
      end
      rd(5'h09, d);
      checks++;
      if (d !== 32'd25) begin
         errors++;
         $display("FAIL periodic_cmp: cmp1=%0d, want 25", d);
      end
      wr(5'h00, 32'd0);
      @(negedge clock);
      force dut.count = 32'hFFFF_FFFB;
      @(negedge clock);
      release dut.count;
      n = 0;
      wr(5'h09, 32'hFFFF_FFFE);
      wr(5'h11, 32'd4);
      wr(5'h04, 32'd2);
      wr(5'h00, 32'd2);
      address = 5'h02;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         #1;
         if (evt[1] && n < 8) begin
            vals[n] = rd_data;
            n++;
         end
      end
      checks++;
      if (n != 2 || vals[0] !== 32'hFFFF_FFFE || vals[1] !== 32'd2) begin
         errors++;
         $display("FAIL wrap_seq: n=%0d %h %h, want 2: fffffffe 00000002",
                  n, vals[0], vals[1]);
      end
      rd(5'h02, d);
      checks++;
      if (d !== 32'd3) begin
         errors++;
         $display("FAIL count_wrap: count=%h, want 3", d);
      end
      rd(5'h09, d);
      checks++;
      if (d !== 32'd6) begin
         errors++;
         $display("FAIL wrap_cmp: cmp1=%h, want 6", d);
      end
      wr(5'h00, 32'd1);
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      wr(5'h03, 32'hF);
      wr(5'h08, 32'd3);
      wr(5'h10, 32'd0);
      wr(5'h04, 32'd1);
      wr(5'h00, 32'd2);
      @(negedge clock);
      wr(5'h03, 32'd1);
      #1;
      checks++;
      if (evt[0] !== 1'b1) begin
         errors++;
         $display("FAIL w1c_race_evt: evt=%b, want bit0 set", evt);
      end
      rd(5'h03, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL w1c_race_pending: pending=%h, want 1", d);
      end
      wr(5'h00, 32'd1);
      wr(5'h09, 32'd3);
      wr(5'h11, 32'd10);
      wr(5'h04, 32'd2);
      wr(5'h00, 32'd2);
      @(negedge clock);
      wr(5'h09, 32'd50);
      #1;
      checks++;
      if (evt[1] !== 1'b1) begin
         errors++;
         $display("FAIL cmp_race_evt: evt=%b, want bit1 set", evt);
      end
      rd(5'h09, d);
      checks++;
      if (d !== 32'd50) begin
         errors++;
         $display("FAIL cmp_race: cmp1=%0d, want 50", d);
      end
      wr(5'h00, 32'd1);
      wr(5'h08, 32'd3);
      wr(5'h10, 32'd0);
      wr(5'h04, 32'd1);
      wr(5'h00, 32'd2);
      @(negedge clock);
      wr(5'h04, 32'd1);
      #1;
      checks++;
      if (evt[0] !== 1'b1) begin
         errors++;
         $display("FAIL arm_race_evt: evt=%b, want bit0 set", evt);
      end
      rd(5'h04, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL arm_race: arm=%h, want 1", d);
      end
      wr(5'h00, 32'd1);
      wr(5'h08, 32'd2);
      wr(5'h09, 32'd2);
      wr(5'h11, 32'd0);
      wr(5'h04, 32'd3);
      wr(5'h03, 32'hF);
      wr(5'h00, 32'd2);
      repeat (2) @(negedge clock);
      rd(5'h02, d);
      checks++;
      if (evt !== 4'b0011 || d !== 32'd2) begin
         errors++;
         $display("FAIL multi_match: evt=%b count=%0d, want 0011 at 2", evt, d);
      end
      @(negedge clock);
      rd(5'h04, d);
      checks++;
      if (evt !== 4'b0000 || d !== 32'd0) begin
         errors++;
         $display("FAIL multi_after: evt=%b arm=%h, want 0000/0", evt, d);
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] d;
      wr(5'h05, 32'd3);
      @(negedge clock);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: irq=%b, want 1", irq);
      end
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (irq !== 1'b0 || evt !== 4'b0000) begin
         errors++;
         $display("FAIL async_out: irq=%b evt=%b, want 0/0000", irq, evt);
      end
      rd(5'h02, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL async_count: count=%0d, want 0", d);
      end
      rd(5'h03, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL async_pending: pending=%h, want 0", d);
      end
      rd(5'h00, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL async_ctrl: ctrl=%h, want 0", d);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_capture;
      logic [31:0] d;
      wr(5'h01, 32'd0);
      wr(5'h00, 32'd3);
`ifdef TIMER_SCHED_CAPTURE_EN
      repeat (100) @(negedge clock);
      capture_in = 1'b1;
      repeat (3) @(negedge clock);
      rd(5'h06, d);
      checks++;
      if (d !== 32'd103) begin
         errors++;
         $display("FAIL capture_val: capture=%0d, want 103", d);
      end
`else
      repeat (20) @(negedge clock);
      rd(5'h06, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL capture_off: capture=%0d, want 0", d);
      end
`endif
      wr(5'h00, 32'd1);
   endtask

   initial begin
      address    = '0;
      wr_data    = '0;
      read       = 1'b0;
      write      = 1'b0;
      cs         = 1'b0;
      capture_in = 1'b0;
      test_reset();
      test_unmapped();
      test_prescale();
      test_oneshot();
      test_periodic();
      test_back_to_back();
      test_async_reset();
      test_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
